// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream -> big-endian words -> SRAM at the reset PC.
// Optional trailing checksum check is compiled in with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0020,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        start_up,
    output logic        done,
    output logic        error
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HDR, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_e;
`else
    typedef enum logic [2:0] {
        S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [WORD_W-1:0]   count_q, count_d;
    logic [WORD_W-1:0]   index_q, index_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]   acc_q, acc_d;
`endif

    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_cs_q, mem_cs_d;
    logic [WORD_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_din_q, mem_din_d;
    logic                start_up_q, start_up_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                accept;
    logic                last_byte;
    logic [WORD_W-1:0]   word;
    logic [WORD_W-1:0]   wr_addr;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        count_d    = count_q;
        index_d    = index_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_d      = acc_q;
`endif
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_din_d  = '0;

        accept    = in_valid && in_ready_q;
        word      = {shift_q, in_data};
        last_byte = accept && (byte_cnt_q == 2'd3);
        wr_addr   = BASE_ADDR + {index_q[WORD_W-3:0], 2'b00};

        // Byte counter wraps every four accepts and holds across stream gaps
        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = word[SHIFT_W-1:0];
        end

        case (state_q)
            S_HDR: begin
                if (last_byte) begin
                    count_d = word;
                    index_d = '0;
                    if (word == '0) begin
                        state_d = S_DONE;
                    end else if (word > WORD_W'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    state_d    = S_WRITE;
                    mem_we_d   = 1'b1;
                    mem_addr_d = {wr_addr[WORD_W-1:2], 2'b00};
                    mem_din_d  = word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    acc_d      = acc_q + word;
`endif
                end
            end
            S_WRITE: begin
                index_d = index_q + WORD_W'(1);
                if (index_d == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (last_byte) begin
                    state_d = (word == acc_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: state_d = S_DONE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_HDR;
        endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
`else
        in_ready_d = (state_d == S_HDR) || (state_d == S_DATA);
`endif
        mem_cs_d   = mem_we_d;
        start_up_d = (state_d == S_DONE) && (state_q != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    // State and output registers; reset wins over any byte accept in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_HDR;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            count_q    <= '0;
            index_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_q      <= '0;
`endif
            in_ready_q <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_cs_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            start_up_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            index_q    <= index_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_q      <= acc_d;
`endif
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            mem_cs_q   <= mem_cs_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            start_up_q <= start_up_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready = in_ready_q;
    assign mem_cs   = mem_cs_q;
    assign mem_oe   = 1'b0;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign start_up = start_up_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
